// File: rtl/cc_speedgenerator_pkg.sv
// Shared definitions for the speed generator: FSM state encoding, the default
// level-0 period and the level-to-limit mapping.
package cc_speedgenerator_pkg;

    // Level-0 period in clock cycles (one second at 50 MHz).
    localparam int unsigned DefaultBaseLimit = 32'd50000000;

    typedef enum logic [1:0] {
        StLoadSetup   = 2'd0,
        StLoadStrobe  = 2'd1,
        StLoadRelease = 2'd2,
        StRun         = 2'd3
    } state_e;

    // Each level halves the period. The caller truncates the result to the bus width.
    function automatic logic [63:0] limit_from_level(input logic [63:0] base,
                                                     input int unsigned level);
        return base >> level;
    endfunction

endpackage

// File: rtl/cc_speedgenerator_edgedetect.sv
// Falling-edge detector with a sticky pending flag.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (history -> 1, pending -> 0)
//   sig_ni : active-low request input; its falling edge is the event
//   clr_i  : consume the request this cycle
//   req_o  : request seen (latched edge, or an edge arriving this very cycle)
module cc_speedgenerator_edgedetect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_ni,
    input  logic clr_i,
    output logic req_o
);

    logic hist_q;
    logic pend_q;
    logic pend_d;
    logic fall;

    assign fall   = hist_q & ~sig_ni;
    // A fresh edge is visible at once so it can be serviced in the cycle it arrives.
    assign req_o  = pend_q | fall;
    // Clearing consumes everything seen this cycle, including a fresh edge.
    assign pend_d = clr_i ? 1'b0 : req_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            hist_q <= sig_ni;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/cc_speedgenerator.sv
// Speed generator: drives the period counter and level limit into the external
// speed comparator, strobes the limit load, and turns the comparator's match
// into a one-cycle tick.
//   CC_SPEEDGENERATOR_CLOCK_50          : clock
//   CC_SPEEDGENERATOR_RESET_InLow       : synchronous active-low reset
//   CC_SPEEDGENERATOR_levelUp_InLow     : level-up request (falling edge)
//   CC_SPEEDGENERATOR_levelReset_InLow  : back-to-level-0 request (falling edge)
//   CC_SPEEDGENERATOR_match_InLow       : comparator result, 0 when data >= limit
//   CC_SPEEDGENERATOR_data_OutBUS       : period counter
//   CC_SPEEDGENERATOR_limit_OutBUS      : limit of the current level
//   CC_SPEEDGENERATOR_loadSignal_OutLow : limit load strobe (falling edge captures)
//   CC_SPEEDGENERATOR_tick_OutHigh      : one pulse per elapsed period
//   CC_SPEEDGENERATOR_level_OutBUS      : current level
//   CC_SPEEDGENERATOR_busy_OutHigh      : load sequence in progress
module cc_speedgenerator
    import cc_speedgenerator_pkg::*;
#(
    parameter int unsigned SPEEDGENERATOR_DATAWIDTH  = 28,
    parameter int unsigned SPEEDGENERATOR_LEVELWIDTH = 3,
    parameter int unsigned SPEEDGENERATOR_MAXLEVEL   = 7,
    parameter int unsigned SPEEDGENERATOR_BASELIMIT  = DefaultBaseLimit
) (
    input  logic                                 CC_SPEEDGENERATOR_CLOCK_50,
    input  logic                                 CC_SPEEDGENERATOR_RESET_InLow,
    input  logic                                 CC_SPEEDGENERATOR_levelUp_InLow,
    input  logic                                 CC_SPEEDGENERATOR_levelReset_InLow,
    input  logic                                 CC_SPEEDGENERATOR_match_InLow,
    output logic [SPEEDGENERATOR_DATAWIDTH-1:0]  CC_SPEEDGENERATOR_data_OutBUS,
    output logic [SPEEDGENERATOR_DATAWIDTH-1:0]  CC_SPEEDGENERATOR_limit_OutBUS,
    output logic                                 CC_SPEEDGENERATOR_loadSignal_OutLow,
    output logic                                 CC_SPEEDGENERATOR_tick_OutHigh,
    output logic [SPEEDGENERATOR_LEVELWIDTH-1:0] CC_SPEEDGENERATOR_level_OutBUS,
    output logic                                 CC_SPEEDGENERATOR_busy_OutHigh
);

    localparam int unsigned DW = SPEEDGENERATOR_DATAWIDTH;
    localparam int unsigned LW = SPEEDGENERATOR_LEVELWIDTH;

    localparam logic [DW-1:0] BaseLimit = DW'(SPEEDGENERATOR_BASELIMIT);
    localparam logic [LW-1:0] MaxLevel  = LW'(SPEEDGENERATOR_MAXLEVEL);

    state_e        state_q, state_d;
    logic [DW-1:0] data_q,  data_d;
    logic [DW-1:0] limit_q, limit_d;
    logic [LW-1:0] level_q, level_d;
    logic          load_q,  load_d;
    logic          tick_q,  tick_d;

    logic          req_up;
    logic          req_rst;
    logic          req_clr;

    cc_speedgenerator_edgedetect u_edge_up (
        .clk_i  (CC_SPEEDGENERATOR_CLOCK_50),
        .rst_ni (CC_SPEEDGENERATOR_RESET_InLow),
        .sig_ni (CC_SPEEDGENERATOR_levelUp_InLow),
        .clr_i  (req_clr),
        .req_o  (req_up)
    );

    cc_speedgenerator_edgedetect u_edge_rst (
        .clk_i  (CC_SPEEDGENERATOR_CLOCK_50),
        .rst_ni (CC_SPEEDGENERATOR_RESET_InLow),
        .sig_ni (CC_SPEEDGENERATOR_levelReset_InLow),
        .clr_i  (req_clr),
        .req_o  (req_rst)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        limit_d = limit_q;
        level_d = level_q;
        load_d  = 1'b1;
        tick_d  = 1'b0;
        req_clr = 1'b0;

        unique case (state_q)
            StLoadSetup: begin
                data_d  = '0;
                load_d  = 1'b0;  // strobe is low for the whole LOAD_STROBE cycle
                state_d = StLoadStrobe;
            end
            StLoadStrobe: begin
                data_d  = '0;
                state_d = StLoadRelease;
            end
            StLoadRelease: begin
                data_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                if (req_rst || req_up) begin
                    // A request abandons any pending match: the period restarts after reload.
                    req_clr = 1'b1;
                    if (req_rst) begin
                        level_d = '0;
                    end else if (level_q < MaxLevel) begin
                        level_d = level_q + 1'b1;
                    end
                    limit_d = DW'(limit_from_level(64'(BaseLimit), 32'(level_d)));
                    data_d  = '0;
                    state_d = StLoadSetup;
                end else if (!CC_SPEEDGENERATOR_match_InLow) begin
                    data_d = '0;
                    tick_d = 1'b1;
                end else begin
                    data_d = data_q + 1'b1;
                end
            end
            default: state_d = StLoadSetup;
        endcase
    end

    always_ff @(posedge CC_SPEEDGENERATOR_CLOCK_50) begin
        if (!CC_SPEEDGENERATOR_RESET_InLow) begin
            state_q <= StLoadSetup;
            data_q  <= '0;
            limit_q <= BaseLimit;
            level_q <= '0;
            load_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            limit_q <= limit_d;
            level_q <= level_d;
            load_q  <= load_d;
            tick_q  <= tick_d;
        end
    end

    assign CC_SPEEDGENERATOR_data_OutBUS       = data_q;
    assign CC_SPEEDGENERATOR_limit_OutBUS      = limit_q;
    assign CC_SPEEDGENERATOR_loadSignal_OutLow = load_q;
    assign CC_SPEEDGENERATOR_tick_OutHigh      = tick_q;
    assign CC_SPEEDGENERATOR_level_OutBUS      = level_q;
    assign CC_SPEEDGENERATOR_busy_OutHigh      = (state_q != StRun);

endmodule

// File: tb/tb_cc_speedgenerator.sv
// Directed bench for cc_speedgenerator with a behavioural comparator in the loop.
module tb_cc_speedgenerator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_n = 1'b1;
    logic       lrst_n = 1'b1;
    logic       match_n;
    logic [7:0] data;
    logic [7:0] limit;
    logic       load_n;
    logic       tick;
    logic [2:0] level;
    logic       busy;

    logic [7:0] cap_lim = 8'd0;
    int         strobes = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    cc_speedgenerator #(
        .SPEEDGENERATOR_DATAWIDTH  (8),
        .SPEEDGENERATOR_LEVELWIDTH (3),
        .SPEEDGENERATOR_MAXLEVEL   (3),
        .SPEEDGENERATOR_BASELIMIT  (16)
    ) dut (
        .CC_SPEEDGENERATOR_CLOCK_50          (clk),
        .CC_SPEEDGENERATOR_RESET_InLow       (rst_n),
        .CC_SPEEDGENERATOR_levelUp_InLow     (up_n),
        .CC_SPEEDGENERATOR_levelReset_InLow  (lrst_n),
        .CC_SPEEDGENERATOR_match_InLow       (match_n),
        .CC_SPEEDGENERATOR_data_OutBUS       (data),
        .CC_SPEEDGENERATOR_limit_OutBUS      (limit),
        .CC_SPEEDGENERATOR_loadSignal_OutLow (load_n),
        .CC_SPEEDGENERATOR_tick_OutHigh      (tick),
        .CC_SPEEDGENERATOR_level_OutBUS      (level),
        .CC_SPEEDGENERATOR_busy_OutHigh      (busy)
    );

    // Comparator model: captures the limit on the strobe's falling edge.
    always @(negedge load_n) begin
        cap_lim = limit;
        strobes = strobes + 1;
    end
    assign match_n = (data >= cap_lim) ? 1'b0 : 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until a tick is seen, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n = n + 1;
        end while (!tick && n < 200);
    endtask

    // Issues a request from RUN, checks the service cycle and runs through the reload.
    task automatic reload(input string tag, input bit up, input bit rs,
                          input int exp_level, input int exp_limit);
        int s0;
        s0 = strobes;
        up_n = ~up;
        lrst_n = ~rs;
        step();
        up_n = 1'b1;
        lrst_n = 1'b1;
        check_eq({tag, ".level"}, 32'(level), exp_level);
        check_eq({tag, ".limit"}, 32'(limit), exp_limit);
        check_eq({tag, ".tick"}, 32'(tick), 0);
        check_eq({tag, ".data"}, 32'(data), 0);
        step();
        check_eq({tag, ".strobe"}, 32'(load_n), 0);
        step();
        step();
        check_eq({tag, ".busy"}, 32'(busy), 0);
        check_eq({tag, ".nstrobes"}, 32'(strobes - s0), 1);
    endtask

    initial begin
        int n;

        // Reset held three cycles.
        rst_n = 1'b0;
        repeat (3) step();
        check_eq("rst.data", 32'(data), 0);
        check_eq("rst.level", 32'(level), 0);
        check_eq("rst.limit", 32'(limit), 16);
        check_eq("rst.load", 32'(load_n), 1);
        check_eq("rst.tick", 32'(tick), 0);
        check_eq("rst.busy", 32'(busy), 1);

        // Release: cycle 1 setup, cycle 2 strobe, cycle 3 release, then RUN.
        rst_n = 1'b1;
        check_eq("c1.load", 32'(load_n), 1);
        step();
        check_eq("c2.load", 32'(load_n), 0);
        check_eq("c2.busy", 32'(busy), 1);
        step();
        check_eq("c3.load", 32'(load_n), 1);
        check_eq("c3.busy", 32'(busy), 1);
        step();
        check_eq("run.busy", 32'(busy), 0);
        check_eq("run.data", 32'(data), 0);
        check_eq("run.strobes", 32'(strobes), 1);
        step();
        check_eq("run.incr", 32'(data), 1);
        wait_tick(n);
        check_eq("p16.first", 32'(n), 16);
        step();
        check_eq("tick.onecycle", 32'(tick), 0);
        wait_tick(n);
        check_eq("p16.second", 32'(n), 16);
        wait_tick(n);
        check_eq("p16.third", 32'(n), 17);

        // Level up to 1.
        reload("up1", 1'b1, 1'b0, 1, 8);
        wait_tick(n);
        check_eq("p8.first", 32'(n), 9);
        wait_tick(n);
        check_eq("p8.second", 32'(n), 9);

        // Up to saturation, then one more.
        reload("up2", 1'b1, 1'b0, 2, 4);
        reload("up3", 1'b1, 1'b0, 3, 2);
        wait_tick(n);
        check_eq("p2.first", 32'(n), 3);
        reload("upsat", 1'b1, 1'b0, 3, 2);
        wait_tick(n);
        check_eq("p2.sat", 32'(n), 3);

        // Both requests at level 2: reset wins.
        reload("lrst", 1'b0, 1'b1, 0, 16);
        reload("up1b", 1'b1, 1'b0, 1, 8);
        reload("up2b", 1'b1, 1'b0, 2, 4);
        reload("both", 1'b1, 1'b1, 0, 16);
        wait_tick(n);
        check_eq("p16.both", 32'(n), 17);

        // Reset asserted during LOAD_STROBE.
        up_n = 1'b0;
        step();
        up_n = 1'b1;
        check_eq("mid.level", 32'(level), 1);
        step();
        check_eq("mid.strobe", 32'(load_n), 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mid.load", 32'(load_n), 1);
        check_eq("mid.level0", 32'(level), 0);
        check_eq("mid.limit", 32'(limit), 16);
        check_eq("mid.busy", 32'(busy), 1);
        check_eq("mid.tick", 32'(tick), 0);
        step();
        check_eq("mid.restrobe", 32'(load_n), 0);
        step();
        step();
        check_eq("mid.run", 32'(busy), 0);
        wait_tick(n);
        check_eq("p16.mid", 32'(n), 17);

        // Request in the exact cycle the comparator matches.
        repeat (16) step();
        check_eq("coll.data", 32'(data), 16);
        up_n = 1'b0;
        step();
        up_n = 1'b1;
        check_eq("coll.tick", 32'(tick), 0);
        check_eq("coll.data0", 32'(data), 0);
        check_eq("coll.level", 32'(level), 1);
        check_eq("coll.busy", 32'(busy), 1);
        step();
        check_eq("coll.tick2", 32'(tick), 0);
        step();
        step();
        check_eq("coll.run", 32'(busy), 0);
        wait_tick(n);
        check_eq("p8.coll", 32'(n), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
